// File: rtl/systolic_array_stream.sv
// N-lane streaming MAC row: x ripples lane to lane, weights skewed per lane, then shift/ReLU/saturate.
// Define SYSTOLIC_ROUND_EN to round half-up ahead of the arithmetic right shift.
module systolic_array_stream #(
  parameter int N       = 16,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int LEN_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [SHIFT_W-1:0]    shift,
  input  logic                  output_layer,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     x_in,
  input  logic [N*DATA_W-1:0]   w_in,
  output logic [DATA_W-1:0]     xout,
  output logic                  xout_valid,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [N*DATA_W-1:0]   result,
  output logic                  busy
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting samples into lane 0
  // DRAIN | last sample still rippling towards lane N-1
  // DONE  | results presented until res_ready
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t r_state, w_next;

  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [SHIFT_W-1:0]  r_shift;
  logic                r_out_layer;
  logic [DATA_W-1:0]   r_x [0:N];
  logic [N:0]          r_v;
  logic [N*DATA_W-1:0] r_result;
  logic [N*DATA_W-1:0] w_post;

  logic w_accept;
  logic w_start_run;
  logic w_start_empty;
  logic w_last;
  logic w_chain_empty;

  assign w_accept      = in_valid && (r_state == S_RUN);
  assign w_start_run   = (r_state == S_IDLE) && start && (len != '0);
  assign w_start_empty = (r_state == S_IDLE) && start && (len == '0);
  assign w_last        = w_accept && ((r_cnt + LEN_W'(1)) == r_len);

  // Only the valids still feeding a lane matter; lane N-1 has already accumulated its slot.
  always_comb begin
    w_chain_empty = 1'b1;
    for (int k = 0; k < N - 1; k++) begin
      if (r_v[k]) w_chain_empty = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = (len != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_chain_empty) w_next = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_out_layer <= 1'b0;
      r_v         <= '0;
      r_result    <= '0;
      for (int k = 0; k <= N; k++) r_x[k] <= '0;
    end else begin
      if (w_start_run) begin
        r_len       <= len;
        r_shift     <= shift;
        r_out_layer <= output_layer;
        r_cnt       <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
      r_v    <= {r_v[N-1:0], w_accept};
      r_x[0] <= w_accept ? x_in : '0;
      for (int k = 1; k <= N; k++) r_x[k] <= r_x[k-1];
      if (w_start_empty)
        r_result <= '0;
      else if ((r_state == S_DRAIN) && w_chain_empty)
        r_result <= w_post;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [DATA_W-1:0]   w_a;
    logic signed [DATA_W-1:0]   w_b;
    logic                       w_en;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_pre;
    logic signed [ACC_W-1:0]    w_sh;
    logic signed [ACC_W-1:0]    w_rl;

    if (i == 0) begin : g_head
      assign w_a  = x_in;
      assign w_b  = w_in[0 +: DATA_W];
      assign w_en = w_accept;
    end else begin : g_tail
      // Lane i sees its weight i cycles late, in step with x rippling down the chain.
      logic [DATA_W-1:0] r_wd [0:i-1];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < i; k++) r_wd[k] <= '0;
        end else begin
          r_wd[0] <= w_accept ? w_in[i*DATA_W +: DATA_W] : '0;
          for (int k = 1; k < i; k++) r_wd[k] <= r_wd[k-1];
        end
      end
      assign w_a  = r_x[i-1];
      assign w_b  = r_wd[i-1];
      assign w_en = r_v[i-1];
    end

    assign w_prod = w_a * w_b;

    always_ff @(posedge clk) begin
      if (reset)            r_acc <= '0;
      else if (w_start_run) r_acc <= '0;
      else if (w_en)        r_acc <= r_acc + ACC_W'(w_prod);
    end

`ifdef SYSTOLIC_ROUND_EN
    assign w_pre = (r_shift != '0) ? (r_acc + (ACC_W'(1) << (r_shift - SHIFT_W'(1)))) : r_acc;
`else
    assign w_pre = r_acc;
`endif
    assign w_sh = w_pre >>> r_shift;
    assign w_rl = (!r_out_layer && w_sh[ACC_W-1]) ? '0 : w_sh;
    assign w_post[i*DATA_W +: DATA_W] = (w_rl > SAT_MAX) ? SAT_MAX[DATA_W-1:0] :
                                        (w_rl < SAT_MIN) ? SAT_MIN[DATA_W-1:0] :
                                                           w_rl[DATA_W-1:0];
  end

  assign result     = r_result;
  assign xout       = r_x[N];
  assign xout_valid = r_v[N];

endmodule

// File: tb/tb_systolic_array_stream.sv
// Scoreboard bench for systolic_array_stream (N=4): directed layers, bubbles, hold, len=0, mid-layer reset.
module tb_systolic_array_stream;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int LW = 8;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [LW-1:0]   len;
  logic [SW-1:0]   shift;
  logic            output_layer;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   x_in;
  logic [N*DW-1:0] w_in;
  logic [DW-1:0]   xout;
  logic            xout_valid;
  logic            res_valid;
  logic            res_ready;
  logic [N*DW-1:0] result;
  logic            busy;

  always #5 clk = ~clk;

  systolic_array_stream #(.N(N), .DATA_W(DW), .ACC_W(AW), .LEN_W(LW), .SHIFT_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .shift(shift),
    .output_layer(output_layer), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .w_in(w_in), .xout(xout), .xout_valid(xout_valid),
    .res_valid(res_valid), .res_ready(res_ready), .result(result), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [N*DW-1:0] exp_q [$];
  logic [N*DW-1:0] mon_exp;
  logic [DW-1:0]   smp_x [0:15];
  logic [N*DW-1:0] smp_w [0:15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every result handshake is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(res_valid), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 64'(result), 64'(mon_exp));
      end
    end
  end

  task automatic start_layer(input int l, input int sh, input bit ol);
    start = 1'b1; len = LW'(l); shift = SW'(sh); output_layer = ol;
    @(posedge clk); #1;
    start = 1'b0; len = 8'hAA; shift = 5'd3; output_layer = ~ol;
  endtask

  task automatic run_layer(input int l, input int sh, input bit ol, input int nslot,
                           input logic [15:0] pat, input bit hold, input logic [N*DW-1:0] exp_r);
    int k;
    int tv;
    bit ev;
    logic [DW-1:0] slot_x [0:23];
    exp_q.push_back(exp_r);
    res_ready = !hold;
    start_layer(l, sh, ol);
    k = 0;
    for (int t = 0; t < nslot + N + 2; t++) begin
      if (t < nslot && pat[t]) begin
        in_valid = 1'b1; x_in = smp_x[k]; w_in = smp_w[k];
        slot_x[t] = smp_x[k];
        k++;
      end else begin
        in_valid = 1'b0; x_in = 8'h7F; w_in = {N{8'h55}};
        if (t < 24) slot_x[t] = '0;
      end
      @(negedge clk);
      check("in_ready", 64'(in_ready), 64'(t < nslot));
      tv = t - N - 1;
      ev = (tv >= 0 && tv < nslot) ? pat[tv] : 1'b0;
      check("xout_valid", 64'(xout_valid), 64'(ev));
      if (ev) check("xout", 64'(xout), 64'(slot_x[tv]));
      check("res_valid", 64'(res_valid), hold ? 64'(t >= nslot + N) : 64'(t == nslot + N));
      check("busy", 64'(busy), 64'(hold || t <= nslot + N));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (hold) begin
      for (int h = 0; h < 3; h++) begin
        start = 1'b1; len = 8'd3;
        @(negedge clk);
        check("hold_res_valid", 64'(res_valid), 64'd1);
        check("hold_result", 64'(result), 64'(exp_r));
        check("hold_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
      end
      res_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("post_hs_busy", 64'(busy), 64'd0);
      check("post_hs_res_valid", 64'(res_valid), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_xout_valid"}, 64'(xout_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_xout"}, 64'(xout), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
  endtask

  task automatic load_t1();
    smp_x[0] = 8'd1; smp_x[1] = 8'd2; smp_x[2] = 8'd3;
    for (int k = 0; k < 3; k++) smp_w[k] = {8'hFF, 8'h02, 8'h02, 8'h02};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; shift = '0; output_layer = 1'b0;
    in_valid = 1'b0; x_in = '0; w_in = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // x=1,2,3, weights 2 (lane3 -1): ReLU clamps lane3
    load_t1();
    run_layer(3, 0, 1'b0, 3, 16'b111, 1'b0, {8'h00, 8'h0C, 8'h0C, 8'h0C});
    // same with ReLU bypassed, results held for a while with start pulses
    run_layer(3, 0, 1'b1, 3, 16'b111, 1'b1, {8'hFA, 8'h0C, 8'h0C, 8'h0C});

    // 100*100*2 >>> 4 = 1250 saturates high; lane3 negative saturates low
    smp_x[0] = 8'd100; smp_x[1] = 8'd100;
    smp_w[0] = {8'h9C, 8'h64, 8'h64, 8'h64};
    smp_w[1] = {8'h9C, 8'h64, 8'h64, 8'h64};
    run_layer(2, 4, 1'b1, 2, 16'b11, 1'b0, {8'h80, 8'h7F, 8'h7F, 8'h7F});
    run_layer(2, 4, 1'b0, 2, 16'b11, 1'b0, {8'h00, 8'h7F, 8'h7F, 8'h7F});

    // acc=-9, shift 1
    smp_x[0] = 8'hF7;
    smp_w[0] = {8'h01, 8'h01, 8'h01, 8'h01};
`ifdef SYSTOLIC_ROUND_EN
    run_layer(1, 1, 1'b1, 1, 16'b1, 1'b0, {4{8'hFC}});
`else
    run_layer(1, 1, 1'b1, 1, 16'b1, 1'b0, {4{8'hFB}});
`endif

    // per-sample weights (i+1)*(k+1): lane i = 30*(i+1), bubble-free then bubbled
    for (int k = 0; k < 4; k++) smp_x[k] = DW'(k + 1);
    smp_w[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    smp_w[1] = {8'd8, 8'd6, 8'd4, 8'd2};
    smp_w[2] = {8'd12, 8'd9, 8'd6, 8'd3};
    smp_w[3] = {8'd16, 8'd12, 8'd8, 8'd4};
    run_layer(4, 0, 1'b0, 4, 16'b1111, 1'b0, {8'h78, 8'h5A, 8'h3C, 8'h1E});
    run_layer(4, 0, 1'b0, 7, 16'b1011001, 1'b0, {8'h78, 8'h5A, 8'h3C, 8'h1E});

    // reset after 2 of 3 samples, then a clean layer
    load_t1();
    start_layer(3, 0, 1'b0);
    in_valid = 1'b1; x_in = smp_x[0]; w_in = smp_w[0];
    @(posedge clk); #1;
    x_in = smp_x[1]; w_in = smp_w[1];
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    run_layer(3, 0, 1'b0, 3, 16'b111, 1'b0, {8'h00, 8'h0C, 8'h0C, 8'h0C});

    // len=0 goes straight to DONE with zero results
    exp_q.push_back('0);
    start_layer(0, 0, 1'b0);
    @(negedge clk);
    check("len0_res_valid", 64'(res_valid), 64'd1);
    check("len0_in_ready", 64'(in_ready), 64'd0);
    check("len0_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("len0_busy_after", 64'(busy), 64'd0);
    check("len0_in_ready_after", 64'(in_ready), 64'd0);
    @(posedge clk); #1;

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array_stream.md
Name: systolic_array_stream

Overview:
Parametrised, handshaked successor to the fixed 16-lane MAC+activation systolic row. N lanes each own one output neuron. A layer of LEN input activations streams in through lane 0 and ripples one lane per cycle, with per-lane weights skewed internally. After draining, the block applies shift, optional ReLU and saturation. It then presents all N results on a valid/ready port, and sits between the layer sequencer and the activation buffer.

Parameters:
N, 16, number of lanes (output neurons), >=1
DATA_W, 8, signed activation/weight/result width
ACC_W, 24, signed accumulator width per lane
LEN_W, 8, width of layer-length field
SHIFT_W, 5, width of shift field

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  begin a layer; sampled only in IDLE
len  in  LEN_W  number of input samples for the layer; latched on start
shift  in  SHIFT_W  arithmetic right shift applied to accumulators; latched on start
output_layer  in  1  1 = bypass ReLU; latched on start
in_valid  in  1  x_in/w_in valid
in_ready  out  1  block accepts a sample
x_in  in  DATA_W  signed input activation
w_in  in  N*DATA_W  weights for this sample; lane i at [i*DATA_W +: DATA_W]
xout  out  DATA_W  x after the last lane, for chaining
xout_valid  out  1  qualifies xout
res_valid  out  1  results valid
res_ready  in  1  consumer takes results
result  out  N*DATA_W  signed results; lane i at [i*DATA_W +: DATA_W]
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high, any state, including mid-layer):
  - State goes to IDLE.
  - All accumulators, skew registers, chain valid bits, result and the sample counter are set to 0.
  - in_ready, res_valid, xout_valid, busy and xout are all 0.
- FSM states:
  - IDLE: in_ready=0.
    - start with len>0 → RUN. Latch len/shift/output_layer and clear all accumulators.
    - start with len=0 → DONE with result all zeros.
  - RUN: in_ready=1.
    - A sample is accepted on any edge where in_valid&&in_ready.
    - The counter increments on each accept.
    - On the accept that makes count==len → DRAIN; in_ready drops the next cycle.
  - DRAIN: in_ready=0.
    - Waits until every chain valid bit is 0, i.e. the last sample has reached lane N-1.
    - Then registers the post-processed results → DONE.
  - DONE: res_valid=1 and result held stable.
    - res_valid&&res_ready → IDLE.
    - start is ignored in DONE, including on the handshake cycle.
- Systolic chain:
  - Lane 0 accumulates x_in*w_in[lane0] on the accept edge.
  - The (x, valid) pair propagates one lane per edge. Lane i accumulates on edge accept+i.
  - The weight for lane i is delayed i cycles through an internal per-lane skew chain. The caller presents all N weights of a sample together with its x.
  - Bubbles (in_valid=0 in RUN) propagate as valid=0. A lane never accumulates on an invalid slot.
  - xout/xout_valid are lane N-1's x/valid, registered one stage after lane N-1.
- Arithmetic:
  - Product is a signed 2*DATA_W-bit value, sign-extended to ACC_W.
  - Accumulator wraps two's-complement; no saturation inside the accumulator.
  - Post-process, per lane, in order:
    1. acc >>> shift (arithmetic).
    2. If output_layer==0, negative values become 0.
    3. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Latency: with no bubbles, last accept on edge E → res_valid high after edge E+N.
- Input values are ignored while in_ready=0.
- shift >= ACC_W is illegal and behaviour is unspecified.

Optional Feature:
SYSTOLIC_ROUND_EN:
- Defined: round half-up before shifting. When shift>0, add 1<<(shift-1) to acc (ACC_W wrap), then shift.
- Undefined: pure truncating arithmetic shift, exactly as described above.

Test Plan:
- N=4, len=3, shift=0, output_layer=0; x=1,2,3; all weights 2 except lane3=-1, no bubbles → lanes0-2 result 12, lane3 0 (ReLU). res_valid rises after edge last_accept+4.
- Same stimulus with output_layer=1 → lane3 result -6; hold res_ready=0 for 5 cycles → result stable and res_valid held; start pulses during the hold are ignored.
- N=4, len=2, x=100,100, w=100, shift=4 → acc 20000>>>4=1250 → saturates to 127; with SYSTOLIC_ROUND_EN, acc=-9, shift=1, output_layer=1 → -4 (without the macro → -5).
- len=4 with in_valid pattern 1,0,0,1,1,0,1 → exactly 4 accepts. Results equal the bubble-free run. xout_valid shows the same bubble pattern delayed N+1 cycles.
- start with len=0 → res_valid next cycle, result all zeros, in_ready never asserted.
- Assert reset for one edge after 2 of 3 samples accepted → IDLE, all outputs 0. A new layer afterwards gives results free of stale accumulation.
